// File: rtl/key_action_mapper.sv
// key_action_mapper: maps configurable scan codes to pulse, held-level or auto-repeat action outputs
module key_action_mapper #(
    parameter int                 N_ACT        = 2,
    parameter logic [9*N_ACT-1:0] ACT_CODES    = {9'h01c, 9'h023},
    parameter int                 MODE         = 0,
    parameter int                 LAST_WINS    = 1,
    parameter int                 CNT_W        = 24,
    parameter logic [CNT_W-1:0]   REPEAT_DELAY = 24'd12_500_000,
    parameter logic [CNT_W-1:0]   REPEAT_RATE  = 24'd5_000_000,
    localparam int                IDX_W        = (N_ACT > 1) ? $clog2(N_ACT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [511:0]     key_down,
    input  logic [8:0]       last_change,
    input  logic             key_valid,
    output logic [N_ACT-1:0] act,
    output logic             active,
    output logic [IDX_W-1:0] act_idx
);
    localparam logic [CNT_W-1:0] DLY_M1  = REPEAT_DELAY - 1'b1;
    localparam logic [CNT_W-1:0] RATE_M1 = REPEAT_RATE - 1'b1;

    logic             active_q, active_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // rep_q: 0 while timing the initial delay, 1 while timing the repeat interval
    logic             rep_q, rep_d;
    logic [N_ACT-1:0] act_q, act_d;
    logic             hit, cur_held, any_held, press, rep_hit;
    logic [IDX_W-1:0] hit_idx, low_idx;

    // Decode the lowest code matching last_change, the lowest held mapped code, and whether the arbitrated key is still down
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_held = 1'b0;
        low_idx  = '0;
        cur_held = 1'b0;
        for (int i = N_ACT - 1; i >= 0; i--) begin
            if (last_change == ACT_CODES[9*i +: 9]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (key_down[ACT_CODES[9*i +: 9]]) begin
                any_held = 1'b1;
                low_idx  = IDX_W'(i);
            end
            if (idx_q == IDX_W'(i)) cur_held = key_down[ACT_CODES[9*i +: 9]];
        end
    end

    assign press = key_valid & key_down[last_change] & hit;

    // Arbitration priority (press, release/fallback, repeat timing) and the next action vector
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        rep_hit  = 1'b0;
        act_d    = '0;
        if (press) begin
            active_d = 1'b1;
            idx_d    = hit_idx;
            cnt_d    = '0;
            rep_d    = 1'b0;
        end else if (active_q && !cur_held) begin
            active_d = any_held;
            idx_d    = any_held ? low_idx : idx_q;
            cnt_d    = '0;
            rep_d    = 1'b0;
        end else if (active_q && MODE == 2) begin
            rep_hit = cnt_q == (rep_q ? RATE_M1 : DLY_M1);
            cnt_d   = rep_hit ? '0 : cnt_q + 1'b1;
            rep_d   = rep_q | rep_hit;
        end
        for (int i = 0; i < N_ACT; i++) begin
            act_d[i] = (MODE == 1 && LAST_WINS == 0) ? key_down[ACT_CODES[9*i +: 9]] :
                       (MODE == 1) ? (active_d && idx_d == IDX_W'(i)) :
                       press ? (hit_idx == IDX_W'(i)) :
                       (rep_hit && idx_q == IDX_W'(i));
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rep_q    <= 1'b0;
            act_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            act_q    <= act_d;
        end
    end

    assign act     = act_q;
    assign active  = active_q;
    assign act_idx = idx_q;
endmodule

// File: tb/tb_key_action_mapper.sv
// tb_key_action_mapper: directed table, repeat timing sequence and randomized model check across six configurations
module tb_key_action_mapper;
    localparam int NI = 6;

    typedef struct {
        logic [4:0] fl;
        logic [8:0] lc;
        logic [1:0] ep;
        logic [1:0] eh1;
        logic [1:0] eh0;
        logic [1:0] edup;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic [1:0]   act0, act1, act2, act3, act4;
    logic [2:0]   act5;
    logic [5:0]   actv;
    logic [4:0]   idx_s;
    logic [1:0]   idx5;
    logic [3:0]   held = '0;

    int vectors = 0;
    int miscompares = 0;
    int now = 0;

    int cfg_n[NI]    = '{2, 2, 2, 2, 2, 3};
    int cfg_mode[NI] = '{0, 1, 1, 2, 0, 2};
    int cfg_lw[NI]   = '{1, 1, 0, 1, 1, 1};
    int cfg_dly[NI]  = '{1, 1, 1, 4, 1, 3};
    int cfg_rate[NI] = '{1, 1, 1, 2, 1, 5};
    logic [8:0] cfg_code[NI][3];
    logic [8:0] codes4[4] = '{9'h01c, 9'h023, 9'h01d, 9'h029};

    bit         m_act[NI];
    int         m_idx[NI];
    int         m_t0[NI];
    logic [2:0] e_act[NI];

    vec_t tbl[16];

    always #5 clk = ~clk;

    key_action_mapper #(.MODE(0)) u_pulse (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act0), .active(actv[0]), .act_idx(idx_s[0]));
    key_action_mapper #(.MODE(1), .LAST_WINS(1)) u_hold_lw (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act1), .active(actv[1]), .act_idx(idx_s[1]));
    key_action_mapper #(.MODE(1), .LAST_WINS(0)) u_hold_lv (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act2), .active(actv[2]), .act_idx(idx_s[2]));
    key_action_mapper #(.MODE(2), .REPEAT_DELAY(24'd4), .REPEAT_RATE(24'd2)) u_rep (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act3), .active(actv[3]), .act_idx(idx_s[3]));
    key_action_mapper #(.MODE(0), .ACT_CODES({9'h01c, 9'h01c})) u_dup (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act4), .active(actv[4]), .act_idx(idx_s[4]));
    key_action_mapper #(.N_ACT(3), .ACT_CODES({9'h01d, 9'h01c, 9'h023}), .MODE(2),
                        .REPEAT_DELAY(24'd3), .REPEAT_RATE(24'd5)) u_rep3 (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
        .act(act5), .active(actv[5]), .act_idx(idx5));

    function automatic logic [2:0] dut_act(int k);
        case (k)
            0: return {1'b0, act0};
            1: return {1'b0, act1};
            2: return {1'b0, act2};
            3: return {1'b0, act3};
            4: return {1'b0, act4};
            default: return act5;
        endcase
    endfunction

    function automatic logic [1:0] dut_idx(int k);
        return (k == 5) ? idx5 : {1'b0, idx_s[k]};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, now, got, exp);
        end
    endtask

    // Reference: last press wins, release falls back to the lowest held key, repeats at delay + n*rate after (re)start
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            int hit, low, el;
            bit press, pulse;
            logic [2:0] e;
            hit = -1;
            low = -1;
            pulse = 1'b0;
            e = '0;
            for (int i = cfg_n[k] - 1; i >= 0; i--) begin
                if (cfg_code[k][i] == last_change) hit = i;
                if (key_down[cfg_code[k][i]]) low = i;
            end
            press = key_valid && key_down[last_change] && hit >= 0;
            if (rst) begin
                m_act[k] = 1'b0;
                m_idx[k] = 0;
            end else if (press) begin
                m_act[k] = 1'b1;
                m_idx[k] = hit;
                m_t0[k] = now;
            end else if (m_act[k] && !key_down[cfg_code[k][m_idx[k]]]) begin
                if (low >= 0) begin
                    m_idx[k] = low;
                    m_t0[k] = now;
                end else m_act[k] = 1'b0;
            end else if (m_act[k]) begin
                el = now - m_t0[k];
                pulse = el == cfg_dly[k] || (el > cfg_dly[k] && (el - cfg_dly[k]) % cfg_rate[k] == 0);
            end
            if (!rst) begin
                if (cfg_mode[k] == 1 && cfg_lw[k] == 0) begin
                    for (int i = 0; i < cfg_n[k]; i++) e[i] = key_down[cfg_code[k][i]];
                end else if (cfg_mode[k] == 1) begin
                    if (m_act[k]) e[m_idx[k]] = 1'b1;
                end else if (press) e[hit] = 1'b1;
                else if (cfg_mode[k] == 2 && pulse) e[m_idx[k]] = 1'b1;
            end
            e_act[k] = e;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        now++;
        model_step();
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model_act[%0d]", k), dut_act(k), e_act[k]);
            chk($sformatf("model_active[%0d]", k), actv[k], m_act[k]);
            if (m_act[k]) chk($sformatf("model_idx[%0d]", k), dut_idx(k), m_idx[k]);
        end
    endtask

    task automatic drive(bit r, bit a, bit d, bit u, bit v, logic [8:0] lc);
        rst = r;
        key_down = '0;
        key_down[9'h01c] = a;
        key_down[9'h023] = d;
        key_down[9'h029] = u;
        key_valid = v;
        last_change = lc;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) cfg_code[k] = '{9'h023, 9'h01c, 9'h000};
        cfg_code[4] = '{9'h01c, 9'h01c, 9'h000};
        cfg_code[5] = '{9'h023, 9'h01c, 9'h01d};

        // fl = {rst, A, D, unmapped 029, key_valid}; expected act for pulse, hold last-wins, hold level, duplicate
        tbl = '{
            '{5'b10000, 9'h000, 2'b00, 2'b00, 2'b00, 2'b00},
            '{5'b01001, 9'h01c, 2'b10, 2'b10, 2'b10, 2'b01},
            '{5'b01000, 9'h01c, 2'b00, 2'b10, 2'b10, 2'b00},
            '{5'b01101, 9'h023, 2'b01, 2'b01, 2'b11, 2'b00},
            '{5'b01100, 9'h023, 2'b00, 2'b01, 2'b11, 2'b00},
            '{5'b01001, 9'h023, 2'b00, 2'b10, 2'b10, 2'b00},
            '{5'b01011, 9'h029, 2'b00, 2'b10, 2'b10, 2'b00},
            '{5'b00001, 9'h01c, 2'b00, 2'b00, 2'b00, 2'b00},
            '{5'b01000, 9'h000, 2'b00, 2'b00, 2'b10, 2'b00},
            '{5'b01001, 9'h01c, 2'b10, 2'b10, 2'b10, 2'b01},
            '{5'b11000, 9'h01c, 2'b00, 2'b00, 2'b00, 2'b00},
            '{5'b01000, 9'h01c, 2'b00, 2'b00, 2'b10, 2'b00},
            '{5'b01000, 9'h01c, 2'b00, 2'b00, 2'b10, 2'b00},
            '{5'b01101, 9'h023, 2'b01, 2'b01, 2'b11, 2'b00},
            '{5'b01001, 9'h01c, 2'b10, 2'b10, 2'b10, 2'b01},
            '{5'b00000, 9'h000, 2'b00, 2'b00, 2'b00, 2'b00}
        };

        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].fl[4], tbl[r].fl[3], tbl[r].fl[2], tbl[r].fl[1], tbl[r].fl[0], tbl[r].lc);
            tick();
            chk("pulse_act", act0, tbl[r].ep);
            chk("hold_lw_act", act1, tbl[r].eh1);
            chk("hold_lv_act", act2, tbl[r].eh0);
            chk("dup_act", act4, tbl[r].edup);
            chk("hold_lw_active", actv[1], |tbl[r].eh1);
            if (|tbl[r].eh1) chk("hold_lw_idx", idx_s[1], tbl[r].eh1[1]);
            if (|tbl[r].edup) chk("dup_idx", idx_s[4], 0);
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        tick();
        for (int n = 1; n <= 16; n++) begin
            drive(1'b0, n <= 12, 1'b0, 1'b0, (n == 1) || (n == 13), 9'h01c);
            tick();
            chk("repeat_seq", act3, (n == 1 || n == 5 || n == 7 || n == 9 || n == 11) ? 2 : 0);
        end

        for (int c = 0; c < 4000; c++) begin
            int s;
            s = $urandom_range(0, 3);
            rst = ($urandom_range(0, 99) == 0);
            key_valid = ($urandom_range(0, 5) == 0);
            last_change = ($urandom_range(0, 9) == 0) ? 9'($urandom) : codes4[s];
            if (key_valid && $urandom_range(0, 3) != 0) held[s] = ~held[s];
            key_down = '0;
            for (int i = 0; i < 4; i++) key_down[codes4[i]] = held[i];
            if ($urandom_range(0, 7) == 0) key_down[9'($urandom)] = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
